data_mem_lsu: RTL
=================

// Module: data_mem_lsu
// PURPOSE
//  Load/store responder for the MEM stage: serves the mem_read/mem_write requests
//  raised by control_unit, using funct3 from the same instruction.
//  Holds a word-organised data RAM and answers each access after a fixed wait.
//  Holds the core with stall until the access completes.
//  Performs byte/half/word size handling and load sign/zero extension.
// PARAMETERS
//  DEPTH    1024  data RAM size in 32-bit words (power of 2); AW = $clog2(DEPTH)
//  LATENCY  2     wait cycles spent in BUSY per access (>=1)
// PORTS
//  clk         in   1   clock; all state updates on rising edge
//  rst         in   1   synchronous active-high reset
//  mem_read    in   1   load request from control_unit
//  mem_write   in   1   store request from control_unit
//  funct3      in   3   instr[14:12]: access size / extension
//  addr        in   32  byte address (ALU result)
//  wdata       in   32  store data (rs2)
//  rdata       out  32  load result, valid when done=1
//  stall       out  1   combinational; freeze PC and pipeline while high
//  done        out  1   one-cycle pulse: access complete
//  misaligned  out  1   qualified by done; misaligned access flagged
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, rdata=0, done=0, misaligned=0. RAM contents are not cleared.
//  A reset during BUSY abandons the access; no RAM write occurs.
//  req = mem_read | mem_write. If both are high: store only; mem_read is ignored.
//  FSM:
//   IDLE: on req, latch addr/wdata/funct3/kind and load cnt=LATENCY-1 -> BUSY.
//   BUSY: if cnt!=0, cnt--. If cnt==0, perform the access at this edge -> RESP.
//         A store write and the rdata register both update at that edge.
//   RESP: done=1 for exactly one cycle -> IDLE. Inputs are ignored in RESP;
//         they still belong to the retiring instruction.
//  stall = (IDLE & req) | BUSY. stall=0 in RESP.
//  Latency: request in cycle N -> done in cycle N+LATENCY+1.
//  Throughput: one access per LATENCY+2 cycles.
//  Index: word = addr[AW+1:2]. Higher address bits are ignored, so the address wraps modulo DEPTH*4.
//  Stores: SB=000 writes byte lane addr[1:0]; SH=001 writes half lane addr[1];
//   SW=010 writes the full word. Other lanes are untouched.
//  Loads: LB=000 and LH=001 sign-extend. LW=010 returns the full word.
//   LBU=100 and LHU=101 zero-extend.
//  Illegal funct3 (load 011/110/111, store 011-111): no RAM change, rdata=0,
//   done still pulses, misaligned=0.
//  rdata holds its value outside RESP and is written only at the access edge;
//   a store access writes 0 to rdata.
//  done/misaligned are 0 in all states other than RESP.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined:
//   - Misaligned cases: half with addr[0]=1; word with addr[1:0]!=0.
//   - For these: no RAM write, rdata=0, misaligned=1 alongside done.
//  LSU_MISALIGN_TRAP_EN undefined:
//   - Half access ignores addr[0]; word access ignores addr[1:0] (forced alignment).
//   - misaligned is tied 0.
// TESTING
//  1 SW 0xDEADBEEF @0x10, then LW @0x10 -> done at N+3 (LATENCY=2), rdata=0xDEADBEEF, stall high 3 cycles.
//  2 SB 0x80 @0x11, then LB @0x11 -> 0xFFFFFF80; LBU -> 0x00000080; word @0x10 = 0xDEAD80EF.
//  3 SH 0x8001 @0x12, then LH @0x12 -> 0xFFFF8001; LHU -> 0x00008001.
//  4 LW @0x13 -> with macro: misaligned=1, rdata=0, RAM unchanged.
//    Without macro: rdata = word @0x10, misaligned=0.
//  5 SW 0x1234 @0x20, rst asserted in BUSY -> outputs 0, IDLE next cycle, later LW @0x20 != 0x1234 (prior value kept).
//  6 mem_read=mem_write=1, SW 0x5 @(DEPTH*4+0x4) -> wraps to word 1.
//    done fires, rdata=0; LW @0x4 -> 0x5.

Source files
------------

// File: rtl/data_mem_lsu.sv
// MEM-stage load/store responder: word-organised data RAM, fixed-latency access,
// byte/half/word lanes with load extension. Optional trap: LSU_MISALIGN_TRAP_EN.
//
// state | meaning
// IDLE  | waiting for mem_read/mem_write; latches the request
// BUSY  | counting down wait cycles; access performed when cnt reaches 0
// RESP  | done pulse for one cycle; inputs ignored
module data_mem_lsu #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        misaligned
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [2:0]    f3_q;
  logic          store_q;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   mem_q [DEPTH];

  logic          req, access, legal, mis, do_op, we;
  logic [AW-1:0] word_idx;
  logic [1:0]    lane;
  logic [31:0]   old_word, shifted, wd, mask, merged, load_v;
  logic [3:0]    be;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic          unused_addr;

  assign req         = mem_read | mem_write;
  assign access      = (state_q == S_BUSY) && (cnt_q == '0);
  assign unused_addr = ^addr[31:AW+2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall = req;
        if (req) begin
          state_d = S_BUSY;
          cnt_d   = CNT_INIT;
        end
      end
      S_BUSY: begin
        stall = 1'b1;
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else             state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign done = (state_q == S_RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Request capture; a store wins when both request lines are high.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && req) begin
      addr_q  <= addr[AW+1:0];
      wdata_q <= wdata;
      f3_q    <= funct3;
      store_q <= mem_write;
    end
  end

  assign word_idx = addr_q[AW+1:2];
  assign lane     = addr_q[1:0];
  assign old_word = mem_q[word_idx];
  assign legal    = store_q ? (f3_q inside {3'b000, 3'b001, 3'b010})
                            : (f3_q inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis_q;
  assign mis = legal && (((f3_q[1:0] == 2'b01) && lane[0]) ||
                         ((f3_q[1:0] == 2'b10) && (lane != 2'b00)));
  always_ff @(posedge clk) begin
    if (rst)         mis_q <= 1'b0;
    else if (access) mis_q <= mis;
  end
  assign misaligned = (state_q == S_RESP) & mis_q;
`else
  assign mis        = 1'b0;
  assign misaligned = 1'b0;
`endif

  assign do_op = legal & ~mis;

  always_comb begin
    be = 4'b1111;
    wd = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        be = 4'b0001 << lane;
        wd = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be = lane[1] ? 4'b1100 : 4'b0011;
        wd = {2{wdata_q[15:0]}};
      end
      default: begin
        be = 4'b1111;
        wd = wdata_q;
      end
    endcase
  end

  assign mask   = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  assign merged = (old_word & ~mask) | (wd & mask);
  assign we     = access & store_q & do_op & ~rst;

  always_ff @(posedge clk) begin
    if (we) mem_q[word_idx] <= merged;
  end

  assign shifted = old_word >> {lane, 3'b000};
  assign byte_v  = shifted[7:0];
  assign half_v  = lane[1] ? old_word[31:16] : old_word[15:0];

  always_comb begin
    case (f3_q)
      3'b000:  load_v = {{24{byte_v[7]}}, byte_v};
      3'b001:  load_v = {{16{half_v[15]}}, half_v};
      3'b010:  load_v = old_word;
      3'b100:  load_v = {24'h0, byte_v};
      3'b101:  load_v = {16'h0, half_v};
      default: load_v = '0;
    endcase
  end

  // rdata only moves at the access edge; stores and rejected accesses return 0.
  always_comb begin
    rdata_d = rdata_q;
    if (access) rdata_d = (store_q || !do_op) ? 32'h0 : load_v;
  end

  assign rdata = rdata_q;

endmodule
